// File: rtl/score_keeper_if.sv
// Game-core event inputs and score/display outputs of score_keeper.
// master = game core / display side, slave = score_keeper.
interface score_keeper_if #(
   parameter int PTS_W = 4
);
   logic             game_start;
   logic             game_over;
   logic             hit;
   logic [PTS_W-1:0] hit_pts;
   logic             penalty;
   logic [PTS_W-1:0] pen_pts;
   logic [31:0]      score;
   logic [3:0]       score_tens;
   logic [3:0]       score_ones;
   logic [31:0]      high_score;
   logic             new_high;
   logic             playing;
   logic             maxed;

   modport master (
      output game_start, game_over, hit, hit_pts, penalty, pen_pts,
      input  score, score_tens, score_ones, high_score, new_high, playing, maxed
   );

   modport slave (
      input  game_start, game_over, hit, hit_pts, penalty, pen_pts,
      output score, score_tens, score_ones, high_score, new_high, playing, maxed
   );
endinterface

// File: rtl/score_keeper.sv
// Saturating 0..MAX_SCORE game score with BCD digits, best-score record and IDLE/PLAY/OVER tracking.
// One-cycle latency from a sampled event edge to all registered outputs; no backpressure.
module score_keeper #(
   parameter int MAX_SCORE = 99,
   parameter int PTS_W     = 4
) (
   input  logic          clk,
   input  logic          reset,
   score_keeper_if.slave sk
);
   localparam int SW = 7;

   typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

   state_t         state_q, state_d;
   logic [SW-1:0]  score_q, score_d;
   logic [SW-1:0]  high_q, high_d;
   logic [3:0]     tens_q, tens_d;
   logic [3:0]     ones_q, ones_d;
   logic           new_high_q, new_high_d;
   logic           playing_q, playing_d;
   logic           maxed_q, maxed_d;
   logic           hit_q, hit_d;
   logic           pen_q, pen_d;

   logic [PTS_W-1:0] hit_pts_w, pen_pts_w;
   logic             hit_rise, pen_rise;
   int               sum;

   assign hit_pts_w = sk.hit_pts;
   assign pen_pts_w = sk.pen_pts;
   assign hit_rise  = sk.hit & ~hit_q;
   assign pen_rise  = sk.penalty & ~pen_q;

   function automatic logic [3:0] tens_of(input logic [SW-1:0] v);
      tens_of = 4'd0;
      for (int i = 1; i <= 9; i++) begin
         if (v >= SW'(10 * i)) tens_of = 4'(i);
      end
   endfunction

   always_comb begin
      state_d    = state_q;
      score_d    = score_q;
      high_d     = high_q;
      new_high_d = 1'b0;
      hit_d      = sk.hit;
      pen_d      = sk.penalty;
      sum        = 0;

      case (state_q)
         IDLE: begin
            if (sk.game_start) begin
               state_d = PLAY;
               score_d = '0;
            end
         end
         PLAY: begin
            if (sk.game_start) begin
               score_d = '0;
            end else if (sk.game_over) begin
               state_d = OVER;
               if (score_q > high_q) begin
                  high_d     = score_q;
                  new_high_d = 1'b1;
               end
            end else begin
               // Hit and penalty in the same cycle net out in one clamped update.
               sum = int'(score_q)
                   + (hit_rise ? int'(hit_pts_w) : 0)
                   - (pen_rise ? int'(pen_pts_w) : 0);
               if (sum < 0)              score_d = '0;
               else if (sum > MAX_SCORE) score_d = SW'(MAX_SCORE);
               else                      score_d = SW'(sum);
            end
         end
         OVER: begin
            if (sk.game_start) begin
               state_d = PLAY;
               score_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Digits and flags derive from score_d so they register together with score.
      tens_d    = tens_of(score_d);
      ones_d    = 4'(score_d - SW'(10 * int'(tens_d)));
      playing_d = (state_d == PLAY);
      maxed_d   = (score_d == SW'(MAX_SCORE));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         score_q    <= '0;
         high_q     <= '0;
         tens_q     <= '0;
         ones_q     <= '0;
         new_high_q <= 1'b0;
         playing_q  <= 1'b0;
         maxed_q    <= 1'b0;
         hit_q      <= 1'b0;
         pen_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         score_q    <= score_d;
         high_q     <= high_d;
         tens_q     <= tens_d;
         ones_q     <= ones_d;
         new_high_q <= new_high_d;
         playing_q  <= playing_d;
         maxed_q    <= maxed_d;
         hit_q      <= hit_d;
         pen_q      <= pen_d;
      end
   end

   assign sk.score      = {{(32-SW){1'b0}}, score_q};
   assign sk.high_score = {{(32-SW){1'b0}}, high_q};
   assign sk.score_tens = tens_q;
   assign sk.score_ones = ones_q;
   assign sk.new_high   = new_high_q;
   assign sk.playing    = playing_q;
   assign sk.maxed      = maxed_q;
endmodule

// File: tb/tb_score_keeper.sv
// Directed checks of score_keeper: scoring, saturation, penalties, high score and async reset.
module tb_score_keeper;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   score_keeper_if #(.PTS_W(4)) sk_bus ();

   score_keeper #(.MAX_SCORE(99), .PTS_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .sk    (sk_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic hit_evt(input logic [3:0] pts);
      sk_bus.hit     = 1'b1;
      sk_bus.hit_pts = pts;
      step();
      sk_bus.hit     = 1'b0;
      step();
   endtask

   task automatic pen_evt(input logic [3:0] pts);
      sk_bus.penalty = 1'b1;
      sk_bus.pen_pts = pts;
      step();
      sk_bus.penalty = 1'b0;
      step();
   endtask

   task automatic start_game();
      sk_bus.game_start = 1'b1;
      step();
      sk_bus.game_start = 1'b0;
   endtask

   task automatic end_game();
      sk_bus.game_over = 1'b1;
      step();
      sk_bus.game_over = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b1;
      sk_bus.game_start = 1'b0;
      sk_bus.game_over  = 1'b0;
      sk_bus.hit        = 1'b0;
      sk_bus.hit_pts    = 4'd0;
      sk_bus.penalty    = 1'b0;
      sk_bus.pen_pts    = 4'd0;
      step();
      step();
      check("rst_score",   sk_bus.score,      0);
      check("rst_high",    sk_bus.high_score, 0);
      check("rst_tens",    32'(sk_bus.score_tens), 0);
      check("rst_ones",    32'(sk_bus.score_ones), 0);
      check("rst_playing", 32'(sk_bus.playing), 0);
      check("rst_maxed",   32'(sk_bus.maxed), 0);
      check("rst_newhigh", 32'(sk_bus.new_high), 0);
      reset = 1'b0;
      step();

      // Hit held high scores only once
      start_game();
      check("start_playing", 32'(sk_bus.playing), 1);
      sk_bus.hit     = 1'b1;
      sk_bus.hit_pts = 4'd7;
      step();
      check("hit7_score", sk_bus.score, 7);
      check("hit7_tens",  32'(sk_bus.score_tens), 0);
      check("hit7_ones",  32'(sk_bus.score_ones), 7);
      repeat (20) step();
      check("hold_score", sk_bus.score, 7);
      sk_bus.hit = 1'b0;
      step();

      // Climb to 95, then saturate at 99
      for (int i = 0; i < 9; i++) hit_evt(4'd9);
      hit_evt(4'd7);
      check("pre95_score", sk_bus.score, 95);
      check("pre95_maxed", 32'(sk_bus.maxed), 0);
      hit_evt(4'd9);
      check("sat_score", sk_bus.score, 99);
      check("sat_tens",  32'(sk_bus.score_tens), 9);
      check("sat_ones",  32'(sk_bus.score_ones), 9);
      check("sat_maxed", 32'(sk_bus.maxed), 1);
      hit_evt(4'd3);
      check("sticky_score", sk_bus.score, 99);

      // Penalties, clamp at zero, netted simultaneous events
      for (int i = 0; i < 6; i++) pen_evt(4'd15);
      pen_evt(4'd5);
      check("pen_to4", sk_bus.score, 4);
      check("pen_maxed", 32'(sk_bus.maxed), 0);
      pen_evt(4'd10);
      check("clamp0", sk_bus.score, 0);
      sk_bus.hit = 1'b1;  sk_bus.hit_pts = 4'd6;
      sk_bus.penalty = 1'b1;  sk_bus.pen_pts = 4'd2;
      step();
      sk_bus.hit = 1'b0;  sk_bus.penalty = 1'b0;
      step();
      check("net_score", sk_bus.score, 4);
      check("net_ones",  32'(sk_bus.score_ones), 4);

      // Game 1 ends at 42; hit edge with game_over is discarded
      hit_evt(4'd15);
      hit_evt(4'd15);
      hit_evt(4'd8);
      check("g1_score", sk_bus.score, 42);
      sk_bus.game_over = 1'b1;
      sk_bus.hit = 1'b1;  sk_bus.hit_pts = 4'd5;
      step();
      sk_bus.game_over = 1'b0;
      check("g1_playing", 32'(sk_bus.playing), 0);
      check("g1_high",    sk_bus.high_score, 42);
      check("g1_pulse",   32'(sk_bus.new_high), 1);
      check("g1_discard", sk_bus.score, 42);
      step();
      check("g1_pulse_end", 32'(sk_bus.new_high), 0);
      sk_bus.hit = 1'b0;
      step();
      hit_evt(4'd5);
      check("over_hit", sk_bus.score, 42);
      check("over_tens", 32'(sk_bus.score_tens), 4);

      // Game 2 ties at 42: no update
      start_game();
      check("g2_clear", sk_bus.score, 0);
      hit_evt(4'd15);
      hit_evt(4'd15);
      hit_evt(4'd12);
      end_game();
      check("g2_pulse", 32'(sk_bus.new_high), 0);
      check("g2_high",  sk_bus.high_score, 42);

      // Game 3 ends at 50: new record
      start_game();
      for (int i = 0; i < 3; i++) hit_evt(4'd15);
      hit_evt(4'd5);
      end_game();
      check("g3_pulse", 32'(sk_bus.new_high), 1);
      check("g3_high",  sk_bus.high_score, 50);

      // game_start beats game_over and a hit edge
      start_game();
      hit_evt(4'd10);
      sk_bus.game_start = 1'b1;
      sk_bus.game_over  = 1'b1;
      sk_bus.hit = 1'b1;  sk_bus.hit_pts = 4'd5;
      step();
      sk_bus.game_start = 1'b0;
      sk_bus.game_over  = 1'b0;
      sk_bus.hit        = 1'b0;
      check("prio_playing", 32'(sk_bus.playing), 1);
      check("prio_score",   sk_bus.score, 0);
      step();

      // Game to 80, then 63 and async reset mid-cycle
      for (int i = 0; i < 5; i++) hit_evt(4'd15);
      hit_evt(4'd5);
      end_game();
      check("g4_high", sk_bus.high_score, 80);
      start_game();
      for (int i = 0; i < 4; i++) hit_evt(4'd15);
      hit_evt(4'd3);
      check("pre_rst_score", sk_bus.score, 63);
      #2;
      reset = 1'b1;
      #1;
      check("arst_score",   sk_bus.score, 0);
      check("arst_high",    sk_bus.high_score, 0);
      check("arst_tens",    32'(sk_bus.score_tens), 0);
      check("arst_ones",    32'(sk_bus.score_ones), 0);
      check("arst_playing", 32'(sk_bus.playing), 0);
      step();
      reset = 1'b0;
      step();
      hit_evt(4'd9);
      check("idle_hit_score",   sk_bus.score, 0);
      check("idle_hit_playing", 32'(sk_bus.playing), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
